// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined add/subtract unit with a valid/ready handshake on both sides.
//
// WIDTH is cut into STAGES equal slices of WIDTH/STAGES bits. Stage k computes slice k
// and registers its borrow/carry out, which becomes the borrow/carry in of stage k+1.
// Each stage register holds the following:
//   - a_q/b_q:  the operand slices still to be processed, shifted down so that the next
//               stage always works on bits [SliceW-1:0].
//   - res_q:    the result slices produced so far, shifted in from the top so that the
//               word is aligned once it leaves the last stage.
//   - mode_q, cy_q, vld_q: per-beat mode, borrow/carry and valid bit.
// The whole pipe advances together when the output is empty or is being consumed.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready = global advance)
//   mode                0 = A - B - Bin, 1 = A + B + Bin
//   A, B, Bin           operands and borrow/carry in
//   out_valid/out_ready result handshake
//   out, Bout           result and borrow/carry out
//   ovf, zero           signed overflow and zero-result flags
//
// Build option: define PIPE_FLAGS_EN to generate the ovf/zero flag registers.
// Without it, ovf and zero are tied to 0.
module pipe_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             Bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SliceW = WIDTH / STAGES;
  localparam int unsigned Last   = STAGES - 1;

  // Stage registers (index k = output of stage k)
  logic             vld_q  [STAGES];
  logic             cy_q   [STAGES];
  logic             mode_q [STAGES];
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] res_q  [STAGES];

  // Stage inputs: ports for stage 0, previous stage register otherwise
  logic             st_v   [STAGES];
  logic             st_c   [STAGES];
  logic             st_m   [STAGES];
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_r   [STAGES];

  logic [SliceW:0]  sum_ext [STAGES];
  logic [WIDTH-1:0] res_d   [STAGES];
  logic             adv;

  assign adv       = ~vld_q[Last] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[Last];
  assign out       = res_q[Last];
  assign Bout      = cy_q[Last];

  always_comb begin
    st_v[0] = in_valid;
    st_c[0] = Bin;
    st_m[0] = mode;
    st_a[0] = A;
    st_b[0] = B;
    st_r[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      st_v[k] = vld_q[k-1];
      st_c[k] = cy_q[k-1];
      st_m[k] = mode_q[k-1];
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_r[k] = res_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      // Bit SliceW of the extended result is the carry (add) or borrow (sub) out.
      if (st_m[k]) begin
        sum_ext[k] = {1'b0, st_a[k][SliceW-1:0]} + {1'b0, st_b[k][SliceW-1:0]}
                   + {{SliceW{1'b0}}, st_c[k]};
      end else begin
        sum_ext[k] = {1'b0, st_a[k][SliceW-1:0]} - {1'b0, st_b[k][SliceW-1:0]}
                   - {{SliceW{1'b0}}, st_c[k]};
      end
      // New slice enters at the top; earlier slices move down one slice width.
      res_d[k] = (st_r[k] >> SliceW)
               | (WIDTH'(sum_ext[k][SliceW-1:0]) << (WIDTH - SliceW));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]  <= 1'b0;
        cy_q[k]   <= 1'b0;
        mode_q[k] <= 1'b0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        res_q[k]  <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]  <= st_v[k];
        cy_q[k]   <= sum_ext[k][SliceW];
        mode_q[k] <= st_m[k];
        a_q[k]    <= st_a[k] >> SliceW;
        b_q[k]    <= st_b[k] >> SliceW;
        res_q[k]  <= res_d[k];
      end
    end
  end

`ifdef PIPE_FLAGS_EN
  logic ovf_d, zero_d, ovf_q, zero_q;
  logic a_msb, b_msb, r_msb;

  // The last stage still holds the top operand slice, so the operand MSBs sit at SliceW-1.
  always_comb begin
    a_msb  = st_a[Last][SliceW-1];
    b_msb  = st_b[Last][SliceW-1];
    r_msb  = sum_ext[Last][SliceW-1];
    if (st_m[Last]) begin
      ovf_d = (a_msb == b_msb) && (r_msb != a_msb);
    end else begin
      ovf_d = (a_msb != b_msb) && (r_msb != a_msb);
    end
    zero_d = (res_d[Last] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined add/subtract unit: the successor to the fixed 32-bit ripple-borrow subtractor in the datapath. `WIDTH` is split into `STAGES` equal slices, one slice per pipeline stage, with the carry/borrow registered between stages. Operands enter through a valid/ready handshake and results leave through one. It sits between the operand-select logic and the writeback mux of the ALU. It adds a run-time add/sub mode, backpressure, and optional status flags.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width in bits; must be a multiple of `STAGES`.
- `STAGES`, 4, number of pipeline stages (slices of `WIDTH/STAGES` bits); 1 ≤ `STAGES` ≤ `WIDTH`.

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  unit accepts the beat this cycle.
- `mode`  in  1  0 = subtract, 1 = add.
- `A`  in  WIDTH  minuend / augend.
- `B`  in  WIDTH  subtrahend / addend.
- `Bin`  in  1  borrow-in (sub) or carry-in (add).
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts the result.
- `out`  out  WIDTH  result.
- `Bout`  out  1  borrow-out (sub) or carry-out (add).
- `ovf`  out  1  signed overflow (only with `PIPE_FLAGS_EN`).
- `zero`  out  1  `out == 0` (only with `PIPE_FLAGS_EN`).

## Operation
- **Subtract (`mode = 0`).** `out = A - B - Bin` mod 2^WIDTH. `Bout = 1` iff unsigned `A < B + Bin`.
- **Add (`mode = 1`).** `out = A + B + Bin` mod 2^WIDTH. `Bout` is the carry out of bit WIDTH-1.
- **Slice k (0 = LSB).** Computes bits `[k*S +: S]`, where `S = WIDTH/STAGES`. Its borrow/carry-in is the registered borrow/carry-out of slice k-1. Slice 0 uses `Bin`.
- **Skew registers.** Upper operand slices and `mode` are delayed so each slice sees its own beat's operands. Lower result slices are delayed so all `out` bits align at the last stage.
- **Per-stage valid.** Each stage holds a valid bit. Bubbles propagate as invalid stages and never produce `out_valid`.
- **Global advance.** `adv = ~out_valid | out_ready`. When `adv = 1`, every stage register (data, borrow, valid) shifts one stage. When `adv = 0`, all stages hold.
- **Input handshake.** `in_ready = adv`. A beat is accepted when `in_valid & in_ready`. If `in_valid = 0` while `adv = 1`, a bubble enters stage 0.
- **Output hold.** Output data and flags stay stable while `out_valid & ~out_ready`.
- **Overflow.** `ovf` is signed overflow of the selected operation: add gives `A[msb] == B[msb] != out[msb]`; sub gives `A[msb] != B[msb]` and `out[msb] != A[msb]`.

## Timing
- **Latency.** Exactly `STAGES` cycles from the accepting edge to `out_valid` high, with no stall. `STAGES = 1` gives a single registered stage.
- **Throughput.** One beat per cycle while `out_ready` stays high.
- **Reset.** With `reset` high at an edge:
  - All valid bits clear.
  - `out_valid`, `out`, `Bout`, `ovf`, `zero` all go to 0.
  - Internal borrow registers go to 0.
  - `in_ready` is 1 in the cycle after reset, since `out_valid = 0`.
- **Reset mid-operation.** In-flight beats are discarded and never emerge.
- **Stall while full.** `in_ready` drops in the same cycle `out_valid & ~out_ready` holds. It is combinational from `out_ready`; there is no registered skid.
- **Simultaneous accept and release.** When a result is consumed and a new beat is accepted on the same edge, both happen; no bubble is inserted.
- **Undriven inputs.** `A`, `B`, `Bin`, `mode` are don't-care when `in_valid = 0`.

## Configuration
- **Macro `PIPE_FLAGS_EN` defined:**
  - The last stage registers `ovf` and `zero` together with `out`, with the same latency and hold rules.
  - Stage MSB operand bits are carried through the pipe for the overflow calculation.
- **Macro not defined:**
  - `ovf` and `zero` are tied to 0.
  - No flag logic or MSB skew registers are generated.
  - `out` and `Bout` behaviour is unchanged.

## Test plan
All scenarios use `WIDTH = 32`, `STAGES = 4`.
1. **Basic subtract with borrow out.** `A = 0`, `B = 1`, `Bin = 0`, `mode = 0`, `out_ready = 1` → 4 cycles later `out = 0xFFFFFFFF`, `Bout = 1`, `zero = 0`.
2. **Cross-slice borrow.** `A = 0x00010000`, `B = 0x00000001`, sub → `out = 0x0000FFFF`, `Bout = 0`. `A = 5`, `B = 5`, `Bin = 0` → `out = 0`, `zero = 1`, `Bout = 0`.
3. **Add with overflow and carry-in.**
   - `A = 0x7FFFFFFF`, `B = 1`, add → `out = 0x80000000`, `ovf = 1`, `Bout = 0`.
   - `A = 0xFFFFFFFF`, `B = 0`, `Bin = 1`, add → `out = 0`, `Bout = 1`, `zero = 1`.
   - Without `PIPE_FLAGS_EN`: `ovf = zero = 0` throughout.
4. **Back-to-back throughput.** Issue 8 consecutive beats (`A = i`, `B = 1`, sub) with `out_ready = 1` → 8 consecutive `out_valid` cycles starting at cycle 4, `out = i - 1`, in order.
5. **Backpressure.**
   - Hold `out_ready = 0` for 3 cycles while the first result is valid → `in_ready = 0`, and `out` / `Bout` are stable.
   - Release → remaining beats emerge in order with none lost or duplicated.
6. **Reset mid-operation.** Assert `reset` for one cycle with 3 beats in flight → next cycle `out_valid = 0`, `out = 0`, `in_ready = 1`. No stale beat ever appears afterwards.
